// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame capture block: default geometry,
// counter/address widths, FSM state encoding and the mono luma helper.
package lcd_pkg;

    localparam int H_ACTIVE_DEF = 480;
    localparam int V_ACTIVE_DEF = 272;
    localparam int ADDR_W       = 16;
    localparam int CNT_W        = 9;
    localparam int LUMA_W       = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VS,
        S_WAIT_DE,
        S_ACTIVE,
        S_DONE
    } state_t;

    // 2*R + G + 2*B on RGB565 tops out at 187, so 8 bits never overflow.
    function automatic logic [LUMA_W-1:0] luma8(input logic [4:0] r,
                                                input logic [5:0] g,
                                                input logic [4:0] b);
        return {2'b00, r, 1'b0} + {2'b00, g} + {2'b00, b, 1'b0};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Registers one sync-style input, normalises it to "active = 1" using POL,
// and flags the cycles where it becomes active (rise) or inactive (fall).
module sync_edge #(
    parameter bit POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            level <= (din == POL);
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/lcd_capture.sv
// Captures one complete RGB565 frame from a DE/HS/VS LCD bus into a 1-bit
// framebuffer at half horizontal resolution (every even pixel, first 256 lines).
module lcd_capture
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int THRESH   = 94,
    parameter int SYNC_POL = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_arm,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_den,
    input  logic [4:0]        i_r,
    input  logic [5:0]        i_g,
    input  logic [4:0]        i_b,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic              o_wdata,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err_line,
    output logic              o_err_frame,
    output logic [2:0]        o_dbg_state
);

    localparam logic [CNT_W-1:0]  X_END   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  Y_END   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [LUMA_W-1:0] LUMA_TH = LUMA_W'(THRESH);

    state_t           state;
    logic [CNT_W-1:0] x, y;
    logic [CNT_W-1:0] x_inc, y_inc, y_end_chk;
    logic [4:0]       r_q, b_q;
    logic [5:0]       g_q;
    logic             hs_q;
    logic             den_lvl, den_rise, den_fall;
    logic             vs_lvl, vs_act, vs_fall;
    logic             wr, white;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= 1'b0;
        end else begin
            r_q  <= i_r;
            g_q  <= i_g;
            b_q  <= i_b;
            hs_q <= i_hsync;
        end
    end

    sync_edge #(.POL(1'b1)) u_den (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .din   (i_den),
        .level (den_lvl),
        .rise  (den_rise),
        .fall  (den_fall)
    );

    sync_edge #(.POL(SYNC_POL != 0)) u_vs (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .din   (i_vsync),
        .level (vs_lvl),
        .rise  (vs_act),
        .fall  (vs_fall)
    );

    // hsync is sampled for observability only; line timing comes from DEN.
    logic unused_ok;
    assign unused_ok = ^{hs_q, vs_lvl, vs_fall};

    assign x_inc     = (x == CNT_MAX) ? x : x + 1'b1;
    assign y_inc     = (y == CNT_MAX) ? y : y + 1'b1;
    assign y_end_chk = den_fall ? y_inc : y;
    assign white     = luma8(r_q, g_q, b_q) >= LUMA_TH;

    // The first pixel of a frame is taken in WAIT_DE, on the same cycle the FSM enters ACTIVE.
    assign wr = den_lvl && !x[0] && !y[CNT_W-1] &&
                ((state == S_ACTIVE) || (state == S_WAIT_DE && den_rise && !vs_act));

    assign o_dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            x            <= '0;
            y            <= '0;
            o_we         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err_line   <= 1'b0;
            o_err_frame  <= 1'b0;
        end else begin
            o_we         <= wr;
            o_frame_done <= 1'b0;
            if (wr) begin
                o_waddr <= {y[7:0], x[CNT_W-1:1]};
                o_wdata <= white;
            end
            case (state)
                S_IDLE: begin
                    if (i_arm) begin
                        state       <= S_WAIT_VS;
                        o_busy      <= 1'b1;
                        o_err_line  <= 1'b0;
                        o_err_frame <= 1'b0;
                        x           <= '0;
                        y           <= '0;
                    end
                end
                S_WAIT_VS: begin
                    if (vs_act) state <= S_WAIT_DE;
                end
                S_WAIT_DE: begin
                    if (vs_act) begin
                        x <= '0;
                        y <= '0;
                    end else if (den_rise) begin
                        state <= S_ACTIVE;
                        x     <= x_inc;
                    end
                end
                S_ACTIVE: begin
                    if (den_lvl) begin
                        x <= x_inc;
                    end else if (den_fall) begin
                        x <= '0;
                        y <= y_inc;
                        if (x != X_END) o_err_line <= 1'b1;
                    end
                    // y_end_chk folds in a line that ends on this same cycle.
                    if (vs_act) begin
                        state        <= S_DONE;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                        if (y_end_chk != Y_END) o_err_frame <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_capture.sv
// Directed frame sequences with randomised pixel colours for lcd_capture,
// scored against a queue of expected framebuffer writes.
module tb_lcd_capture;

    localparam int H  = 16;
    localparam int V  = 272;
    localparam int TH = 94;
    localparam int WRITES_PER_FRAME = 256 * (H / 2);

    logic        clk = 1'b0;
    logic        rst_n, arm, hs, vs, den;
    logic [4:0]  r, b;
    logic [5:0]  g;
    logic        we, wdata, busy, done, err_line, err_frame;
    logic [15:0] waddr;
    logic [2:0]  dbg_state;

    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] last_addr = '0;
    logic [16:0] exp_q[$];
    logic        den_d1 = 1'b0;
    logic        den_d2 = 1'b0;

    always #5 clk = ~clk;

    lcd_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .THRESH   (TH),
        .SYNC_POL (0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_arm        (arm),
        .i_hsync      (hs),
        .i_vsync      (vs),
        .i_den        (den),
        .i_r          (r),
        .i_g          (g),
        .i_b          (b),
        .o_we         (we),
        .o_waddr      (waddr),
        .o_wdata      (wdata),
        .o_busy       (busy),
        .o_frame_done (done),
        .o_err_line   (err_line),
        .o_err_frame  (err_frame),
        .o_dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int luma_of(input logic [4:0] rr, input logic [5:0] gg, input logic [4:0] bb);
        return 2 * int'(rr) + int'(gg) + 2 * int'(bb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: all white; otherwise a mix of white, black, the threshold pair and random colours
    task automatic drive_pixel(input int mode, input int row, input int col, input bit cap);
        int         sel;
        logic [4:0] pr, pb;
        logic [5:0] pg;
        sel = (mode == 0) ? 0 : int'($urandom_range(0, 4));
        case (sel)
            0: begin pr = 5'd31; pg = 6'd63; pb = 5'd31; end
            1: begin pr = 5'd0;  pg = 6'd0;  pb = 5'd0;  end
            2: begin pr = 5'd15; pg = 6'd31; pb = 5'd16; end
            3: begin pr = 5'd15; pg = 6'd32; pb = 5'd16; end
            default: begin
                pr = 5'($urandom_range(0, 31));
                pg = 6'($urandom_range(0, 63));
                pb = 5'($urandom_range(0, 31));
            end
        endcase
        r = pr; g = pg; b = pb; den = 1'b1;
        if (cap && row < 256 && (col % 2) == 0)
            exp_q.push_back({(luma_of(pr, pg, pb) >= TH) ? 1'b1 : 1'b0, 16'(row * 256 + col / 2)});
        tick();
    endtask

    task automatic hblank();
        den = 1'b0; r = '0; g = '0; b = '0;
        for (int k = 0; k < 4; k++) begin
            hs = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            tick();
        end
        hs = 1'b1;
    endtask

    task automatic run_lines(input int first, input int n, input int short_row, input int mode, input bit cap);
        int np;
        for (int row = first; row < first + n; row++) begin
            np = (row == short_row) ? H - 1 : H;
            for (int col = 0; col < np; col++) drive_pixel(mode, row, col, cap);
            hblank();
        end
    endtask

    task automatic vsync_pulse();
        vs = 1'b0;
        repeat (3) tick();
        vs = 1'b1;
        repeat (3) tick();
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // write monitor: every strobe must trail a DEN-high input by two cycles and match the model
    always @(negedge clk) begin
        if (we === 1'b1) begin
            check("we_den_2cyc", 32'(den_d2), 1);
            check("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("waddr", 32'(waddr), 32'(e[15:0]));
                check("wdata", 32'(wdata), 32'(e[16]));
            end
            wr_cnt++;
            last_addr = waddr;
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("busy_in_done", 32'(busy), 0);
        end
        den_d2 = den_d1;
        den_d1 = den;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, d0;
        rst_n = 1'b0; arm = 1'b0; hs = 1'b1; vs = 1'b1; den = 1'b0;
        r = '0; g = '0; b = '0;
        repeat (3) tick();
        check("rst_we", 32'(we), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err_line", 32'(err_line), 0);
        check("rst_err_frame", 32'(err_frame), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // full white frame
        wr0 = wr_cnt; d0 = done_cnt;
        arm_pulse();
        check("busy_after_arm", 32'(busy), 1);
        vsync_pulse();
        check("busy_wait_de", 32'(busy), 1);
        run_lines(0, V, -1, 0, 1);
        check("busy_active", 32'(busy), 1);
        vsync_pulse();
        repeat (3) tick();
        check("white_writes", 32'(wr_cnt - wr0), WRITES_PER_FRAME);
        check("white_last_addr", 32'(last_addr), 32'(255 * 256 + (H - 2) / 2));
        check("white_done", 32'(done_cnt - d0), 1);
        check("white_err_line", 32'(err_line), 0);
        check("white_err_frame", 32'(err_frame), 0);
        check("white_busy_end", 32'(busy), 0);
        check("white_q_empty", 32'(exp_q.size()), 0);

        // short line, plus an arm pulse while busy that must be ignored
        wr0 = wr_cnt; d0 = done_cnt;
        arm_pulse();
        vsync_pulse();
        run_lines(0, 7, 5, 1, 1);
        check("short_err_line", 32'(err_line), 1);
        check("short_err_frame", 32'(err_frame), 0);
        arm_pulse();
        check("arm_busy_busy", 32'(busy), 1);
        check("arm_busy_keeps_err", 32'(err_line), 1);
        run_lines(7, V - 7, -1, 1, 1);
        vsync_pulse();
        repeat (3) tick();
        check("short_done", 32'(done_cnt - d0), 1);
        check("short_writes", 32'(wr_cnt - wr0), WRITES_PER_FRAME);
        check("short_err_line_end", 32'(err_line), 1);
        check("short_err_frame_end", 32'(err_frame), 0);
        check("short_q_empty", 32'(exp_q.size()), 0);
        repeat (5) tick();
        check("err_line_sticky", 32'(err_line), 1);
        arm_pulse();
        check("err_line_cleared", 32'(err_line), 0);

        // 270-line frame
        wr0 = wr_cnt; d0 = done_cnt;
        vsync_pulse();
        run_lines(0, 270, -1, 1, 1);
        vsync_pulse();
        repeat (3) tick();
        check("f270_done", 32'(done_cnt - d0), 1);
        check("f270_err_frame", 32'(err_frame), 1);
        check("f270_err_line", 32'(err_line), 0);
        check("f270_writes", 32'(wr_cnt - wr0), WRITES_PER_FRAME);
        check("f270_q_empty", 32'(exp_q.size()), 0);

        // 300-line frame: nothing written past line 255
        wr0 = wr_cnt; d0 = done_cnt;
        arm_pulse();
        check("err_frame_cleared", 32'(err_frame), 0);
        vsync_pulse();
        run_lines(0, 300, -1, 1, 1);
        vsync_pulse();
        repeat (3) tick();
        check("f300_done", 32'(done_cnt - d0), 1);
        check("f300_err_frame", 32'(err_frame), 1);
        check("f300_writes", 32'(wr_cnt - wr0), WRITES_PER_FRAME);
        check("f300_q_empty", 32'(exp_q.size()), 0);

        // empty frame while waiting for DEN restarts silently, then a clean random frame
        wr0 = wr_cnt; d0 = done_cnt;
        arm_pulse();
        vsync_pulse();
        vsync_pulse();
        check("restart_busy", 32'(busy), 1);
        check("restart_no_done", 32'(done_cnt - d0), 0);
        check("restart_err_frame", 32'(err_frame), 0);
        run_lines(0, V, -1, 1, 1);
        vsync_pulse();
        repeat (3) tick();
        check("rand_done", 32'(done_cnt - d0), 1);
        check("rand_err_line", 32'(err_line), 0);
        check("rand_err_frame", 32'(err_frame), 0);
        check("rand_writes", 32'(wr_cnt - wr0), WRITES_PER_FRAME);
        check("rand_q_empty", 32'(exp_q.size()), 0);

        // one-cycle reset in the middle of line 100
        d0 = done_cnt;
        arm_pulse();
        vsync_pulse();
        run_lines(0, 100, -1, 1, 1);
        for (int col = 0; col < 5; col++) drive_pixel(1, 100, col, 1);
        rst_n = 1'b0;
        drive_pixel(1, 100, 5, 0);
        rst_n = 1'b1;
        check("midrst_we", 32'(we), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        exp_q.delete();
        wr0 = wr_cnt;
        for (int col = 6; col < H; col++) drive_pixel(1, 100, col, 0);
        hblank();
        run_lines(101, V - 101, -1, 1, 0);
        vsync_pulse();
        repeat (3) tick();
        check("midrst_no_writes", 32'(wr_cnt - wr0), 0);
        check("midrst_no_done", 32'(done_cnt - d0), 0);
        check("midrst_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
